// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with ALUOp/funct decode, registered result, start/done handshake
// and an iterative unsigned multiply/divide path (RV32M subset).
module alu_exec_unit #(
    parameter int unsigned XLEN   = 32,
    parameter bit          EN_MDU = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      alu_op_class,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic            imm_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            branch_taken
);
    localparam int unsigned LOGX = $clog2(XLEN);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MUL_IT = 2'd1;
    localparam logic [1:0] DIV_IT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            busy_d, done_d, zero_d, br_d;
    logic [XLEN-1:0] result_d;
    logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, dvs_q, dvs_d;
    logic            hi_sel_q, hi_sel_d;
    logic [LOGX-1:0] cnt_q, cnt_d;

    logic            is_md, is_mul, is_div;
    logic [XLEN-1:0] sum, diff, alu_res;
    logic [LOGX-1:0] shamt;
    logic            lt_s, lt_u, eq, br_res;

    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign shamt = op_b[LOGX-1:0];
    assign lt_s  = $signed(op_a) < $signed(op_b);
    assign lt_u  = op_a < op_b;
    assign eq    = (op_a == op_b);

    // M-extension ops exist only for register-register class 01 in an MDU build
    assign is_md  = EN_MDU && (alu_op_class == 2'b01) && funct7_0 && !imm_op;
    assign is_mul = is_md && ((funct3 == 3'b000) || (funct3 == 3'b011));
    assign is_div = is_md && ((funct3 == 3'b101) || (funct3 == 3'b111));

    // Single-cycle result and branch decision
    always_comb begin
        alu_res = sum;
        br_res  = 1'b0;
        case (alu_op_class)
            2'b01: begin
                if (!is_md) begin
                    case (funct3)
                        3'b000:  alu_res = (funct7_5 && !imm_op) ? diff : sum;
                        3'b001:  alu_res = op_a << shamt;
                        3'b010:  alu_res = XLEN'(lt_s);
                        3'b011:  alu_res = XLEN'(lt_u);
                        3'b100:  alu_res = op_a ^ op_b;
                        3'b101:  alu_res = funct7_5 ? $unsigned($signed(op_a) >>> shamt)
                                                    : (op_a >> shamt);
                        3'b110:  alu_res = op_a | op_b;
                        default: alu_res = op_a & op_b;
                    endcase
                end
            end
            2'b10: begin
                alu_res = diff;
                case (funct3)
                    3'b000:  br_res = eq;
                    3'b001:  br_res = !eq;
                    3'b100:  br_res = lt_s;
                    3'b101:  br_res = !lt_s;
                    3'b110:  br_res = lt_u;
                    3'b111:  br_res = !lt_u;
                    default: br_res = 1'b0;
                endcase
            end
            default: alu_res = sum;
        endcase
    end

    // Shift-add multiply step on {acc,lo}; restoring divide step with lo as quotient
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n, rem_n, quo_n;

    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
    assign mul_hi_n  = mul_sum[XLEN:1];
    assign mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
    assign div_shift = {acc_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, dvs_q};
    assign rem_n     = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    assign quo_n     = {lo_q[XLEN-2:0], !div_diff[XLEN]};

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result;
        zero_d   = zero;
        br_d     = branch_taken;
        acc_d    = acc_q;
        lo_d     = lo_q;
        dvs_d    = dvs_q;
        hi_sel_d = hi_sel_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (is_mul) begin
                        acc_d    = '0;
                        lo_d     = op_b;
                        dvs_d    = op_a;
                        hi_sel_d = (funct3 == 3'b011);
                        busy_d   = 1'b1;
                        state_d  = MUL_IT;
                    end else if (is_div) begin
                        acc_d    = '0;
                        lo_d     = op_a;
                        dvs_d    = op_b;
                        hi_sel_d = (funct3 == 3'b111);
                        busy_d   = 1'b1;
                        state_d  = DIV_IT;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        br_d     = br_res;
                        done_d   = 1'b1;
                    end
                end
            end
            MUL_IT, DIV_IT: begin
                if (state_q == MUL_IT) begin
                    acc_d = mul_hi_n;
                    lo_d  = mul_lo_n;
                end else begin
                    acc_d = rem_n;
                    lo_d  = quo_n;
                end
                cnt_d = cnt_q + LOGX'(1);
                if (cnt_q == LOGX'(XLEN - 1)) begin
                    result_d = hi_sel_q ? acc_d : lo_d;
                    zero_d   = (result_d == '0);
                    br_d     = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            zero         <= 1'b1;
            branch_taken <= 1'b0;
            acc_q        <= '0;
            lo_q         <= '0;
            dvs_q        <= '0;
            hi_sel_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            busy         <= busy_d;
            done         <= done_d;
            result       <= result_d;
            zero         <= zero_d;
            branch_taken <= br_d;
            acc_q        <= acc_d;
            lo_q         <= lo_d;
            dvs_q        <= dvs_d;
            hi_sel_q     <= hi_sel_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expectations, a monitor
// pops one per done pulse and checks result, zero, branch_taken and latency.
module tb_alu_exec_unit;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, start, start2;
    logic [1:0]      cls;
    logic [2:0]      f3;
    logic            f75, f70, imm;
    logic [XLEN-1:0] a, b;
    logic            busy, done, zero, br;
    logic [XLEN-1:0] result;
    logic            busy2, done2, zero2, br2;
    logic [XLEN-1:0] result2;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(XLEN), .EN_MDU(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_op_class(cls), .funct3(f3),
        .funct7_5(f75), .funct7_0(f70), .imm_op(imm), .op_a(a), .op_b(b),
        .busy(busy), .done(done), .result(result), .zero(zero), .branch_taken(br)
    );

    alu_exec_unit #(.XLEN(XLEN), .EN_MDU(1'b0)) dut_nomdu (
        .clk(clk), .reset(reset), .start(start2), .alu_op_class(cls), .funct3(f3),
        .funct7_5(f75), .funct7_0(f70), .imm_op(imm), .op_a(a), .op_b(b),
        .busy(busy2), .done(done2), .result(result2), .zero(zero2), .branch_taken(br2)
    );

    typedef struct {
        logic [31:0] res;
        logic        br;
        int          due;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
            end else begin
                e = sb.pop_front();
                check($sformatf("op%0d_result", e.id), result, e.res);
                check($sformatf("op%0d_zero", e.id), {31'b0, zero}, {31'b0, (e.res == 32'h0)});
                check($sformatf("op%0d_branch", e.id), {31'b0, br}, {31'b0, e.br});
                check($sformatf("op%0d_done_cycle", e.id), 32'(cyc), 32'(e.due));
                check($sformatf("op%0d_busy_low", e.id), {31'b0, busy}, 32'h0);
            end
        end
    end

    task automatic issue(input int id, input logic [1:0] c, input logic [2:0] f,
                         input logic s5, input logic s0, input logic im,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic eb, input bit iter, input bit push);
        exp_t e;
        @(negedge clk);
        cls = c; f3 = f; f75 = s5; f70 = s0; imm = im; a = x; b = y;
        start = 1'b1;
        if (push) begin
            e.res = er;
            e.br  = eb;
            e.due = cyc + 1 + (iter ? int'(XLEN) : 0);
            e.id  = id;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending ops expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected simulation end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        cls = 2'b00; f3 = 3'b000; f75 = 1'b0; f70 = 1'b0; imm = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",   {31'b0, busy}, 32'h0);
        check("reset_done",   {31'b0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        check("reset_zero",   {31'b0, zero}, 32'h1);
        check("reset_branch", {31'b0, br},   32'h0);
        reset = 1'b0;

        issue(1, 2'b00, 3'b000, 0, 0, 0, 32'd10, 32'd20, 32'd30, 0, 0, 1);
        drain();

        // Reset mid-MUL: aborted op must never report done
        issue(2, 2'b01, 3'b000, 0, 1, 0, 32'd7, 32'd9, 32'd63, 0, 1, 0);
        repeat (5) @(posedge clk);
        #2 check("mid_mul_busy", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        check("abort_busy",   {31'b0, busy}, 32'h0);
        check("abort_done",   {31'b0, done}, 32'h0);
        check("abort_result", result, 32'h0);
        check("abort_zero",   {31'b0, zero}, 32'h1);
        check("abort_branch", {31'b0, br},   32'h0);
        @(negedge clk) reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", {31'b0, busy}, 32'h0);

        // ALU sweep, back-to-back every cycle
        issue(3,  2'b01, 3'b000, 1, 0, 0, 32'd5,        32'd7,  32'hFFFFFFFE, 0, 0, 1);
        issue(4,  2'b01, 3'b101, 1, 0, 0, 32'h80000000, 32'd4,  32'hF8000000, 0, 0, 1);
        issue(5,  2'b01, 3'b101, 0, 0, 0, 32'h80000000, 32'd4,  32'h08000000, 0, 0, 1);
        issue(6,  2'b01, 3'b010, 0, 0, 0, 32'hFFFFFFFF, 32'd1,  32'h1,        0, 0, 1);
        issue(7,  2'b01, 3'b011, 0, 0, 0, 32'hFFFFFFFF, 32'd1,  32'h0,        0, 0, 1);
        issue(8,  2'b01, 3'b000, 1, 0, 1, 32'd5,        32'd7,  32'd12,       0, 0, 1);
        issue(9,  2'b01, 3'b001, 0, 0, 0, 32'd1,        32'h3F, 32'h80000000, 0, 0, 1);
        issue(10, 2'b01, 3'b100, 0, 0, 0, 32'hF0F0,     32'h0FF0, 32'hFF00,   0, 0, 1);
        issue(11, 2'b01, 3'b110, 0, 0, 0, 32'hF0F0,     32'h0FF0, 32'hFFF0,   0, 0, 1);
        issue(12, 2'b01, 3'b111, 0, 0, 0, 32'hF0F0,     32'h0FF0, 32'h00F0,   0, 0, 1);
        issue(13, 2'b01, 3'b011, 0, 1, 1, 32'd2,        32'd3,  32'h1,        0, 0, 1);
        issue(14, 2'b01, 3'b101, 1, 0, 1, 32'h80000000, 32'd4,  32'hF8000000, 0, 0, 1);
        drain();

        // Branch compares
        issue(20, 2'b10, 3'b000, 0, 0, 0, 32'd3,        32'd3, 32'h0,        1, 0, 1);
        issue(21, 2'b10, 3'b001, 0, 0, 0, 32'd3,        32'd3, 32'h0,        0, 0, 1);
        issue(22, 2'b10, 3'b100, 0, 0, 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1, 0, 1);
        issue(23, 2'b10, 3'b110, 0, 0, 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 0, 0, 1);
        issue(24, 2'b10, 3'b101, 0, 0, 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 0, 0, 1);
        issue(25, 2'b10, 3'b111, 0, 0, 0, 32'd0,        32'd0, 32'h0,        1, 0, 1);
        issue(26, 2'b10, 3'b010, 0, 0, 0, 32'd3,        32'd3, 32'h0,        0, 0, 1);
        issue(27, 2'b00, 3'b000, 0, 0, 0, 32'd3,        32'd3, 32'd6,        0, 0, 1);
        drain();

        // MUL with busy profile; a start and operand change mid-flight must be ignored
        issue(30, 2'b01, 3'b000, 0, 1, 0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 0, 1, 1);
        for (int i = 0; i < int'(XLEN); i++) begin
            check($sformatf("mul_busy_%0d", i), {31'b0, busy}, 32'h1);
            if (i == 10) begin
                start = 1'b1; cls = 2'b00; a = 32'd1; b = 32'd1;
            end
            if (i == 11) begin
                start = 1'b0; a = 32'd123;
            end
            @(posedge clk);
            #1;
        end
        check("mul_busy_end", {31'b0, busy}, 32'h0);
        drain();

        issue(31, 2'b01, 3'b011, 0, 1, 0, 32'hFFFFFFFF, 32'd2, 32'h1,        0, 1, 1);
        drain();
        issue(32, 2'b01, 3'b101, 0, 1, 0, 32'd100,      32'd7, 32'd14,       0, 1, 1);
        drain();
        issue(33, 2'b01, 3'b111, 0, 1, 0, 32'd100,      32'd7, 32'd2,        0, 1, 1);
        drain();
        issue(34, 2'b01, 3'b101, 0, 1, 0, 32'd5,        32'd0, 32'hFFFFFFFF, 0, 1, 1);
        drain();
        issue(35, 2'b01, 3'b111, 0, 1, 0, 32'd5,        32'd0, 32'd5,        0, 1, 1);
        drain();
        issue(36, 2'b01, 3'b001, 0, 1, 0, 32'd3,        32'd4, 32'd7,        0, 0, 1);
        issue(37, 2'b01, 3'b000, 0, 1, 1, 32'd3,        32'd4, 32'd7,        0, 0, 1);
        drain();

        // Start accepted in the done cycle of a MUL
        issue(40, 2'b01, 3'b000, 0, 1, 0, 32'd6, 32'd7, 32'd42, 0, 1, 1);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_done_seen", {31'b0, done}, 32'h1);
        issue(41, 2'b00, 3'b000, 0, 0, 0, 32'd1, 32'd1, 32'd2, 0, 0, 1);
        drain();

        // Build without MDU: MUL encoding is an ADD with latency 1
        @(negedge clk);
        cls = 2'b01; f3 = 3'b000; f75 = 1'b0; f70 = 1'b1; imm = 1'b0; a = 32'd3; b = 32'd4;
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        check("nomdu_done",   {31'b0, done2},  32'h1);
        check("nomdu_result", result2,         32'd7);
        check("nomdu_busy",   {31'b0, busy2},  32'h0);
        check("nomdu_zero",   {31'b0, zero2},  32'h0);
        check("nomdu_branch", {31'b0, br2},    32'h0);
        @(posedge clk);
        #1 check("nomdu_done_pulse", {31'b0, done2}, 32'h0);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
